// File: rtl/mii_tx_frame_gen_if.sv
// mii_tx_frame_gen_if: signal bundle between the MII frame generator and its user, PHY and RS
// Signals: start/frame_len/seed (frame request), CRS/COL (from the PHY),
//   TXD/TX_EN/TX_ER (to the RS), busy/done/excess_col/attempts (status).
// master: the generator side; slave: the user/PHY/RS side.
interface mii_tx_frame_gen_if;
  logic start;
  logic [10:0] frame_len;
  logic [7:0] seed;
  logic CRS, COL;
  logic [3:0] TXD;
  logic TX_EN, TX_ER;
  logic busy, done, excess_col;
  logic [4:0] attempts;
  modport master (
    input start, frame_len, seed, CRS, COL,
    output TXD, TX_EN, TX_ER, busy, done, excess_col, attempts
  );
  modport slave (
    output start, frame_len, seed, CRS, COL,
    input TXD, TX_EN, TX_ER, busy, done, excess_col, attempts
  );
endinterface

// File: rtl/mii_tx_frame_gen.sv
// mii_tx_frame_gen: MII transmit frame generator with carrier deferral, jam and binary backoff
// Ports: TX_CLK (nibble clock), reset (async, active high), m (mii_tx_frame_gen_if.master:
//   start/frame_len/seed request, CRS/COL from the PHY, TXD/TX_EN/TX_ER to the RS,
//   busy/done/excess_col/attempts status).
// Define MII_TX_FCS_EN to append the CRC-32 FCS after the data bytes.
module mii_tx_frame_gen (
  input logic TX_CLK,
  input logic reset,
  mii_tx_frame_gen_if.master m
);
  typedef enum logic [2:0] {
    IDLE, DEFER, PREAMBLE, DATA,
`ifdef MII_TX_FCS_EN
    FCS,
`endif
    JAM, BACKOFF, IFG
  } state_t;
  state_t state;
  logic [10:0] len, b, b1, last_b;
  logic [7:0] sd, cur, nxt;
  logic [4:0] ipg;
  logic [3:0] n, k;
  logic h;
  logic [16:0] bo;
  logic [15:0] lfsr;
  logic [9:0] r;
  logic col_hit;
  assign b1 = b + 11'd1;
  // the frame always carries at least 60 bytes, zero padded
  assign last_b = len < 11'd60 ? 11'd59 : len - 11'd1;
  assign cur = b < len ? sd + b[7:0] : 8'h00;
  assign nxt = b1 < len ? sd + b1[7:0] : 8'h00;
  // attempts has not yet been incremented when the jam ends, so it already equals attempts_next-1
  assign k = m.attempts < 5'd10 ? m.attempts[3:0] : 4'd10;
  assign r = lfsr[9:0] & ((10'd1 << k) - 10'd1);
  assign m.TX_ER = 1'b0;
`ifdef MII_TX_FCS_EN
  logic [31:0] crc, crc_n, fcs;
  logic [2:0] f;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 8; i++) x = (x[0] ^ d[i]) ? (x >> 1) ^ 32'hEDB88320 : x >> 1;
    return x;
  endfunction
  assign crc_n = crc_byte(crc, cur);
  assign fcs = ~crc;
  assign col_hit = m.COL && (state == PREAMBLE || state == DATA || state == FCS);
`else
  assign col_hit = m.COL && (state == PREAMBLE || state == DATA);
`endif
  always_ff @(posedge TX_CLK or posedge reset)
    if (reset) begin
      state <= IDLE;
      m.TXD <= 4'h0;
      m.TX_EN <= 1'b0;
      m.busy <= 1'b0;
      m.done <= 1'b0;
      m.excess_col <= 1'b0;
      m.attempts <= 5'd0;
      lfsr <= 16'hACE1;
      len <= '0;
      b <= '0;
      sd <= '0;
      ipg <= '0;
      n <= '0;
      h <= 1'b0;
      bo <= '0;
`ifdef MII_TX_FCS_EN
      crc <= '1;
      f <= '0;
`endif
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      m.done <= 1'b0;
      m.excess_col <= 1'b0;
      if (col_hit) begin
        state <= JAM;
        m.TXD <= 4'h5;
        n <= 4'd0;
      end else
        case (state)
          IDLE:
            if (m.start) begin
              len <= m.frame_len == 11'd0 ? 11'd1 : m.frame_len;
              sd <= m.seed;
              m.attempts <= 5'd1;
              m.busy <= 1'b1;
              ipg <= 5'd0;
              state <= DEFER;
            end
          DEFER:
            if (m.CRS) ipg <= 5'd0;
            else if (ipg == 5'd23) begin
              state <= PREAMBLE;
              m.TX_EN <= 1'b1;
              m.TXD <= 4'h5;
              n <= 4'd0;
            end else ipg <= ipg + 5'd1;
          PREAMBLE:
            if (n == 4'd15) begin
              state <= DATA;
              b <= '0;
              h <= 1'b0;
              m.TXD <= sd[3:0];
`ifdef MII_TX_FCS_EN
              crc <= '1;
`endif
            end else begin
              n <= n + 4'd1;
              m.TXD <= n == 4'd14 ? 4'hD : 4'h5;
            end
          DATA:
            if (!h) begin
              m.TXD <= cur[7:4];
              h <= 1'b1;
            end else if (b == last_b) begin
`ifdef MII_TX_FCS_EN
              crc <= crc_n;
              f <= 3'd0;
              m.TXD <= ~crc_n[3:0];
              state <= FCS;
`else
              m.TX_EN <= 1'b0;
              m.TXD <= 4'h0;
              ipg <= 5'd0;
              state <= IFG;
`endif
            end else begin
              b <= b1;
              h <= 1'b0;
              m.TXD <= nxt[3:0];
`ifdef MII_TX_FCS_EN
              crc <= crc_n;
`endif
            end
`ifdef MII_TX_FCS_EN
          FCS:
            if (f == 3'd7) begin
              m.TX_EN <= 1'b0;
              m.TXD <= 4'h0;
              ipg <= 5'd0;
              state <= IFG;
            end else begin
              f <= f + 3'd1;
              m.TXD <= fcs[{f + 3'd1, 2'b00} +: 4];
            end
`endif
          JAM:
            if (n == 4'd7) begin
              m.TX_EN <= 1'b0;
              m.TXD <= 4'h0;
              ipg <= 5'd0;
              if (m.attempts == 5'd16) begin
                m.excess_col <= 1'b1;
                m.busy <= 1'b0;
                state <= IDLE;
              end else begin
                m.attempts <= m.attempts + 5'd1;
                bo <= {r, 7'd0} - 17'd1;
                state <= r == 10'd0 ? DEFER : BACKOFF;
              end
            end else n <= n + 4'd1;
          BACKOFF:
            if (bo == '0) begin
              ipg <= 5'd0;
              state <= DEFER;
            end else bo <= bo - 17'd1;
          IFG:
            if (ipg == 5'd23) begin
              m.done <= 1'b1;
              m.busy <= 1'b0;
              state <= IDLE;
            end else ipg <= ipg + 5'd1;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_mii_tx_frame_gen.sv
// tb_mii_tx_frame_gen: randomized self-checking bench for mii_tx_frame_gen against a nibble-stream model
`timescale 1ns/1ps
module tb_mii_tx_frame_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mii_tx_frame_gen_if bus();
  mii_tx_frame_gen dut (.TX_CLK(clk), .reset(rst), .m(bus));
  int tests = 0;
  int fails = 0;
  int viol = 0;
  int cap_wait;
  logic [3:0] cap[$];
  logic [3:0] exp_q[$];
`ifdef MII_TX_FCS_EN
  localparam int FCS_NIB = 8;
`else
  localparam int FCS_NIB = 0;
`endif
  // line rules: TX_ER never set, TXD idles at zero whenever TX_EN is low
  always @(negedge clk)
    if (bus.TX_ER !== 1'b0 || (bus.TX_EN === 1'b0 && bus.TXD !== 4'h0)) viol++;
  // expected nibble stream of one whole frame: preamble, SFD, padded bytes low nibble first, FCS
  function automatic void build(int len, logic [7:0] sd);
    int l;
    int nb;
    logic [31:0] crc;
    logic [7:0] bt;
    l = (len == 0) ? 1 : len;
    nb = (l < 60) ? 60 : l;
    crc = 32'hFFFFFFFF;
    exp_q = {};
    repeat (15) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    for (int i = 0; i < nb; i++) begin
      bt = (i < l) ? 8'(int'(sd) + i) : 8'h00;
      exp_q.push_back(bt[3:0]);
      exp_q.push_back(bt[7:4]);
      for (int j = 0; j < 8; j++) crc = (crc[0] ^ bt[j]) ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    crc = ~crc;
    for (int j = 0; j < FCS_NIB; j++) exp_q.push_back(crc[4*j +: 4]);
  endfunction
  function automatic int first_diff();
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i]) return i;
    return -1;
  endfunction
  task automatic pulse_start(int len, logic [7:0] sd);
    bus.frame_len = 11'(len);
    bus.seed = sd;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic capture(int limit);
    cap = {};
    cap_wait = 0;
    while (!bus.TX_EN && cap_wait < limit) begin
      @(negedge clk);
      cap_wait++;
    end
    while (bus.TX_EN && cap.size() < 4000) begin
      cap.push_back(bus.TXD);
      @(negedge clk);
    end
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run_frame(string name, int len, logic [7:0] sd);
    int n;
    build(len, sd);
    pulse_start(len, sd);
    tests++;
    if (bus.busy !== 1'b1 || bus.attempts !== 5'd1) begin
      fails++;
      $display("FAIL %s_start: busy=%b attempts=%0d, want busy=1 attempts=1", name, bus.busy, bus.attempts);
    end
    capture(100);
    tests++;
    if (cap_wait != 24) begin
      fails++;
      $display("FAIL %s_ipg: TX_EN rose after %0d cycles, want 24", name, cap_wait);
    end
    tests++;
    if (cap.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s_length: %0d nibbles, want %0d", name, cap.size(), exp_q.size());
    end
    n = first_diff();
    tests++;
    if (n >= 0) begin
      fails++;
      $display("FAIL %s_content: nibble %0d is %h, want %h", name, n, cap[n], exp_q[n]);
    end
    bus.COL = 1'b1;
    wait_done(n);
    bus.COL = 1'b0;
    tests++;
    if (n != 24 || bus.busy !== 1'b0 || bus.attempts !== 5'd1) begin
      fails++;
      $display("FAIL %s_done: done after %0d cycles busy=%b attempts=%0d, want 24/0/1", name, n, bus.busy, bus.attempts);
    end
  endtask
  task automatic test_reset();
    bus.start = 1'b0;
    bus.frame_len = '0;
    bus.seed = '0;
    bus.CRS = 1'b0;
    bus.COL = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.TX_EN, bus.TX_ER, bus.TXD, bus.busy, bus.done, bus.excess_col, bus.attempts} !== 14'd0) begin
      fails++;
      $display("FAIL reset_values: en=%b er=%b txd=%h busy=%b done=%b exc=%b att=%0d, want all 0",
               bus.TX_EN, bus.TX_ER, bus.TXD, bus.busy, bus.done, bus.excess_col, bus.attempts);
    end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    tests++;
    if (bus.TX_EN !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: TX_EN=%b busy=%b, want 0/0", bus.TX_EN, bus.busy);
    end
  endtask
  task automatic test_min_frame();
    run_frame("min_frame", 64, 8'h00);
    tests++;
    if (cap.size() != 144 + FCS_NIB || cap.size() < 20 || {cap[16], cap[17], cap[18], cap[19]} !== 16'h0010) begin
      fails++;
      $display("FAIL min_frame_shape: %0d nibbles, want %0d starting 0,0,1,0 after SFD", cap.size(), 144 + FCS_NIB);
    end
  endtask
  task automatic test_padding();
    run_frame("padding", 10, 8'hF0);
    tests++;
    if (cap.size() != 136 + FCS_NIB || cap.size() < 38 || {cap[16], cap[17], cap[34], cap[35], cap[36]} !== 20'h0F9F0) begin
      fails++;
      $display("FAIL padding_shape: %0d nibbles, want %0d with F0..F9 then 00", cap.size(), 136 + FCS_NIB);
    end
  endtask
  task automatic test_random_frames();
    int lens[6] = '{0, 1, 59, 60, 61, 0};
    lens[5] = $urandom_range(62, 120);
    foreach (lens[i]) run_frame("random_frame", lens[i], 8'($urandom));
  endtask
  task automatic test_deferral();
    int len;
    int n;
    logic [7:0] sd;
    len = $urandom_range(1, 80);
    sd = 8'($urandom);
    build(len, sd);
    bus.CRS = 1'b1;
    bus.COL = 1'b1;
    pulse_start(len, sd);
    repeat (39) @(negedge clk);
    bus.CRS = 1'b0;
    bus.COL = 1'b0;
    capture(200);
    tests++;
    if (cap_wait != 24) begin
      fails++;
      $display("FAIL deferral_wait: TX_EN rose %0d cycles after CRS fell, want 24", cap_wait);
    end
    n = first_diff();
    tests++;
    if (n >= 0 || cap.size() != exp_q.size()) begin
      fails++;
      $display("FAIL deferral_frame: %0d nibbles first diff %0d, want %0d nibbles intact", cap.size(), n, exp_q.size());
    end
    wait_done(n);
    tests++;
    if (n != 24 || bus.attempts !== 5'd1) begin
      fails++;
      $display("FAIL deferral_done: done after %0d attempts=%0d, want 24/1", n, bus.attempts);
    end
  endtask
  task automatic test_single_collision();
    int len;
    int n;
    int jam_ok;
    logic [3:0] pre[$];
    logic [7:0] sd;
    len = $urandom_range(20, 80);
    sd = 8'($urandom);
    build(len, sd);
    pulse_start(len, sd);
    n = 0;
    while (!bus.TX_EN && n < 100) begin
      @(negedge clk);
      n++;
    end
    pre = {};
    for (int i = 1; i <= 20; i++) begin
      pre.push_back(bus.TXD);
      if (i < 20) @(negedge clk);
    end
    n = 0;
    for (int i = 0; i < 20; i++) if (pre[i] !== exp_q[i]) n++;
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL collision_prefix: %0d of 20 nibbles wrong before the collision, want 0", n);
    end
    bus.COL = 1'b1;
    jam_ok = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.COL = 1'b0;
      if (bus.TX_EN === 1'b1 && bus.TXD === 4'h5) jam_ok++;
    end
    @(negedge clk);
    tests++;
    if (jam_ok != 8 || bus.TX_EN !== 1'b0 || bus.attempts !== 5'd2) begin
      fails++;
      $display("FAIL collision_jam: %0d jam nibbles then TX_EN=%b attempts=%0d, want 8/0/2", jam_ok, bus.TX_EN, bus.attempts);
    end
    capture(1000);
    tests++;
    if (cap_wait != 24 && cap_wait != 152) begin
      fails++;
      $display("FAIL collision_backoff: TX_EN low %0d cycles, want 24 or 152", cap_wait);
    end
    n = first_diff();
    tests++;
    if (n >= 0 || cap.size() != exp_q.size()) begin
      fails++;
      $display("FAIL collision_resend: %0d nibbles first diff %0d, want %0d intact", cap.size(), n, exp_q.size());
    end
    wait_done(n);
    tests++;
    if (n != 24 || bus.attempts !== 5'd2 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL collision_done: done after %0d attempts=%0d busy=%b, want 24/2/0", n, bus.attempts, bus.busy);
    end
  endtask
  task automatic test_excess_collisions();
    int n;
    int bl;
    int k;
    int bursts = 0;
    int bad_burst = 0;
    int bad_gap = 0;
    int bad_stat = 0;
    int stray = 0;
    bus.COL = 1'b1;
    pulse_start(30, 8'($urandom));
    for (int b = 1; b <= 16; b++) begin
      n = 0;
      while (!bus.TX_EN && n < 140000) begin
        @(negedge clk);
        n++;
      end
      k = (b - 1 < 10) ? b - 1 : 10;
      if (b == 1 ? n != 24 : (n < 24 || (n - 24) % 128 != 0 || (n - 24) / 128 >= (1 << k))) bad_gap++;
      bl = 0;
      while (bus.TX_EN && bl < 30) begin
        if (bus.TXD !== 4'h5) bad_burst++;
        bl++;
        @(negedge clk);
      end
      if (bl == 9) bursts++;
      if (bus.excess_col !== (b == 16) || bus.attempts !== 5'((b < 16) ? b + 1 : 16)) bad_stat++;
    end
    tests++;
    if (bursts != 16 || bad_burst != 0) begin
      fails++;
      $display("FAIL excess_bursts: %0d nine-nibble jam bursts with %0d non-5 nibbles, want 16/0", bursts, bad_burst);
    end
    tests++;
    if (bad_gap != 0) begin
      fails++;
      $display("FAIL excess_backoff: %0d gaps outside 24+r*128 with r<2^k, want 0", bad_gap);
    end
    tests++;
    if (bad_stat != 0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL excess_status: %0d bad excess_col/attempts samples busy=%b, want 0/0", bad_stat, bus.busy);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.TX_EN !== 1'b0 || bus.excess_col !== 1'b0 || bus.done !== 1'b0) stray++;
    end
    bus.COL = 1'b0;
    tests++;
    if (stray != 0) begin
      fails++;
      $display("FAIL excess_quiet: %0d cycles with TX_EN/excess_col/done set after giving up, want 0", stray);
    end
  endtask
  task automatic test_reset_mid_frame();
    int n = 0;
    logic en_before;
    pulse_start(64, 8'($urandom));
    while (!bus.TX_EN && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (49) @(negedge clk);
    en_before = bus.TX_EN;
    rst = 1'b1;
    #1;
    tests++;
    if (en_before !== 1'b1 || {bus.TX_EN, bus.TX_ER, bus.TXD, bus.busy, bus.done, bus.excess_col, bus.attempts} !== 14'd0) begin
      fails++;
      $display("FAIL reset_mid_frame: en_before=%b then en=%b txd=%h busy=%b att=%0d, want 1 then all 0",
               en_before, bus.TX_EN, bus.TXD, bus.busy, bus.attempts);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.TX_EN !== 1'b0 || bus.busy !== 1'b0) n++;
    end
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL reset_no_resume: %0d cycles active after reset release, want 0", n);
    end
  endtask
  task automatic test_start_ignored();
    int n;
    logic [7:0] sd;
    sd = 8'($urandom);
    build(25, sd);
    pulse_start(25, sd);
    repeat (5) @(negedge clk);
    pulse_start(100, ~sd);
    capture(100);
    n = first_diff();
    tests++;
    if (n >= 0 || cap.size() != exp_q.size()) begin
      fails++;
      $display("FAIL start_ignored_frame: %0d nibbles first diff %0d, want %0d intact", cap.size(), n, exp_q.size());
    end
    wait_done(n);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.TX_EN !== 1'b0) n++;
    end
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL start_ignored_extra: TX_EN high %0d cycles after done, want 0", n);
    end
  endtask
  task automatic test_back_to_back();
    run_frame("back_to_back_a", $urandom_range(1, 90), 8'($urandom));
    run_frame("back_to_back_b", $urandom_range(1, 90), 8'($urandom));
  endtask
  task automatic test_line_rules();
    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL line_rules: %0d samples with TX_ER set or TXD nonzero while idle, want 0", viol);
    end
  endtask
  initial begin
    test_reset();
    test_min_frame();
    test_padding();
    test_random_frames();
    test_deferral();
    test_single_collision();
    test_excess_collisions();
    test_reset_mid_frame();
    test_start_ignored();
    test_back_to_back();
    test_line_rules();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
